patrick_motion: RTL and testbench

- Downstream of patrick_jump. Consumes its per-frame horizontal step Ball_X_Move and a jump request, and integrates them into the sprite's screen position once per video frame.
- Owns a vertical jump/gravity state machine and clamps the position to the playfield.
- Outputs feed the sprite renderer / color mapper directly.

---
 rtl/patrick_pkg.sv | 32 +++
 rtl/patrick_motion_frame_tick.sv | 26 ++
 rtl/patrick_motion.sv | 202 ++++++++++++++++++++
 tb/tb_patrick_motion.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/patrick_pkg.sv
// patrick_pkg
// Shared definitions for the Patrick sprite pipeline: the vertical motion
// state encoding, the screen geometry and the default jump physics. The
// renderer and collision logic import the same constants, so tuning happens
// here once.
// Contents:
//   motion_state_t - GROUND / RISE / FALL
//   SCREEN_W/H     - visible resolution
//   SPRITE_W       - sprite width, sets the rightmost legal X
//   DEF_*          - default jump speed, gravity and terminal fall speed
//   sext12         - sign-extend a 10-bit step into 12-bit signed arithmetic
package patrick_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SPRITE_W     = 20;

  localparam int DEF_JUMP_V   = 12;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_MAX_FALL = 12;

  function automatic logic signed [11:0] sext12(input logic [9:0] v);
    return $signed({{2{v[9]}}, v});
  endfunction

endpackage

// File: rtl/patrick_motion_frame_tick.sv
// frame_tick_detect
// Turns the vsync-derived frame_clk level into a single-cycle tick on its
// rising edge. One flop of history; any per-frame block can reuse it.
// Ports:
//   CLK       in  system clock
//   Reset     in  asynchronous, active-high reset (clears the history)
//   frame_clk in  frame strobe, already synchronous to CLK
//   tick      out high for exactly one CLK cycle per frame_clk rise
module frame_tick_detect (
  input  logic CLK,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic r_frame_d;

  // History flop; a frame_clk held high only ticks on its first cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_frame_d <= 1'b0;
    else       r_frame_d <= frame_clk;
  end

  assign tick = frame_clk & ~r_frame_d;

endmodule

// File: rtl/patrick_motion.sv
// patrick_motion
// Integrates the per-frame horizontal step from patrick_jump and a jump
// request into the sprite position, once per video frame. X is clamped to
// the playfield; Y is driven by a GROUND/RISE/FALL gravity state machine.
// Outputs feed the sprite renderer / color mapper directly.
// Ports:
//   CLK         in  system clock
//   Reset       in  asynchronous, active-high reset
//   frame_clk   in  frame strobe, synchronous to CLK
//   Ball_X_Move in  signed 10-bit X step per frame
//   jump_req    in  jump request (pulse or level)
//   Ball_X_Pos  out current X
//   Ball_Y_Pos  out current Y (top-left origin, grows downward)
//   airborne    out high whenever the state is not GROUND
//   Ball_Y_Vel  out vertical speed magnitude
// Build option:
//   PATRICK_DOUBLE_JUMP_EN - allow one extra jump per airtime.
module patrick_motion
  import patrick_pkg::*;
#(
  parameter int X_START  = 320,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = SCREEN_W - SPRITE_W,
  parameter int GROUND_Y = SCREEN_H - 80,
  parameter int Y_MIN    = 0,
  parameter int JUMP_V   = DEF_JUMP_V,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] Ball_X_Move,
  input  logic       jump_req,
  output logic [9:0] Ball_X_Pos,
  output logic [9:0] Ball_Y_Pos,
  output logic       airborne,
  output logic [9:0] Ball_Y_Vel
);

  // Arithmetic runs one bit wider than 11 so that X_MAX plus the largest
  // positive step still compares correctly instead of wrapping negative.
  localparam logic signed [11:0] P_X_START  = 12'(X_START);
  localparam logic signed [11:0] P_X_MIN    = 12'(X_MIN);
  localparam logic signed [11:0] P_X_MAX    = 12'(X_MAX);
  localparam logic signed [11:0] P_GROUND_Y = 12'(GROUND_Y);
  localparam logic signed [11:0] P_Y_MIN    = 12'(Y_MIN);
  localparam logic signed [11:0] P_JUMP_V   = 12'(JUMP_V);
  localparam logic signed [11:0] P_GRAVITY  = 12'(GRAVITY);
  localparam logic signed [11:0] P_MAX_FALL = 12'(MAX_FALL);

  logic          w_tick;
  logic          w_jump;
  logic          r_pending;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [9:0]    r_vel;
  motion_state_t r_state;

  logic signed [11:0] w_x_sum;
  logic signed [11:0] w_y_up;
  logic signed [11:0] w_y_dn;
  logic signed [11:0] w_vel_dn;
  logic signed [11:0] w_vel_up;
  logic signed [11:0] w_vel_fall;
  logic [9:0]         w_x_nxt;
  logic [9:0]         w_y_nxt;
  logic [9:0]         w_vel_nxt;
  motion_state_t      w_state_nxt;

`ifdef PATRICK_DOUBLE_JUMP_EN
  logic r_used;
  logic w_used_nxt;
`endif

  frame_tick_detect u_tick (
    .CLK       (CLK),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (w_tick)
  );

  // A request arriving on the tick cycle itself counts for that tick.
  assign w_jump = r_pending | jump_req;

  // Pending latch: set by any request, consumed by every tick whether or
  // not the jump is accepted.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)         r_pending <= 1'b0;
    else if (w_tick)   r_pending <= 1'b0;
    else if (jump_req) r_pending <= 1'b1;
  end

  // Horizontal path: signed step, clamped to the playfield, no wrap.
  always_comb begin
    w_x_sum = $signed({2'b00, r_x}) + sext12(Ball_X_Move);
    w_x_nxt = w_x_sum[9:0];
    if (w_x_sum < P_X_MIN)      w_x_nxt = P_X_MIN[9:0];
    else if (w_x_sum > P_X_MAX) w_x_nxt = P_X_MAX[9:0];
  end

  // Vertical path: candidate results for both directions are formed up
  // front, then the state picks which one applies this frame.
  always_comb begin
    w_y_up      = $signed({2'b00, r_y}) - $signed({2'b00, r_vel});
    w_vel_dn    = $signed({2'b00, r_vel}) - P_GRAVITY;
    w_vel_up    = $signed({2'b00, r_vel}) + P_GRAVITY;
    w_vel_fall  = (w_vel_up > P_MAX_FALL) ? P_MAX_FALL : w_vel_up;
    w_y_dn      = $signed({2'b00, r_y}) + w_vel_fall;
    w_y_nxt     = r_y;
    w_vel_nxt   = r_vel;
    w_state_nxt = r_state;
`ifdef PATRICK_DOUBLE_JUMP_EN
    w_used_nxt  = r_used;
`endif

    case (r_state)
      GROUND: begin
        // Takeoff tick only loads the speed; Y starts moving next frame.
        w_y_nxt = P_GROUND_Y[9:0];
        if (w_jump) begin
          w_vel_nxt   = P_JUMP_V[9:0];
          w_state_nxt = RISE;
        end else begin
          w_vel_nxt   = 10'd0;
        end
      end
      RISE: begin
        if (w_y_up < P_Y_MIN) begin
          w_y_nxt     = P_Y_MIN[9:0];
          w_vel_nxt   = 10'd0;
          w_state_nxt = FALL;
        end else begin
          w_y_nxt = w_y_up[9:0];
          if (w_vel_dn <= 12'sd0) begin
            w_vel_nxt   = 10'd0;
            w_state_nxt = FALL;
          end else begin
            w_vel_nxt   = w_vel_dn[9:0];
          end
        end
      end
      FALL: begin
        if (w_y_dn >= P_GROUND_Y) begin
          w_y_nxt     = P_GROUND_Y[9:0];
          w_vel_nxt   = 10'd0;
          w_state_nxt = GROUND;
`ifdef PATRICK_DOUBLE_JUMP_EN
          w_used_nxt  = 1'b0;
`endif
        end else begin
          w_y_nxt   = w_y_dn[9:0];
          w_vel_nxt = w_vel_fall[9:0];
        end
      end
      default: begin
        w_y_nxt     = P_GROUND_Y[9:0];
        w_vel_nxt   = 10'd0;
        w_state_nxt = GROUND;
      end
    endcase

`ifdef PATRICK_DOUBLE_JUMP_EN
    // Mid-air jump overrides the normal airborne update and freezes Y for
    // this frame, just like a takeoff from the ground.
    if ((r_state != GROUND) && w_jump && !r_used) begin
      w_y_nxt     = r_y;
      w_vel_nxt   = P_JUMP_V[9:0];
      w_state_nxt = RISE;
      w_used_nxt  = 1'b1;
    end
`endif
  end

  // Position, speed and state only move on the frame tick.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_x     <= P_X_START[9:0];
      r_y     <= P_GROUND_Y[9:0];
      r_vel   <= 10'd0;
      r_state <= GROUND;
    end else if (w_tick) begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_vel   <= w_vel_nxt;
      r_state <= w_state_nxt;
    end
  end

`ifdef PATRICK_DOUBLE_JUMP_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)       r_used <= 1'b0;
    else if (w_tick) r_used <= w_used_nxt;
  end
`endif

  assign Ball_X_Pos = r_x;
  assign Ball_Y_Pos = r_y;
  assign Ball_Y_Vel = r_vel;
  assign airborne   = (r_state != GROUND);

endmodule

// File: tb/tb_patrick_motion.sv
// tb_patrick_motion
// Drives frame ticks, X steps and jump requests into patrick_motion and
// compares every frame against a behavioural model through a queue. A
// second instance with a low ground line exercises the ceiling clamp.
// Honours PATRICK_DOUBLE_JUMP_EN in its expectations.
module tb_patrick_motion;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] Ball_X_Move;
  logic       jump_req;
  logic [9:0] Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel;
  logic       airborne;
  logic [9:0] cX, cY, cVel;
  logic       cAir;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] vel;
    logic       air;
  } obs_t;

  obs_t sbQ[$];
  obs_t got, exp;
  int   nVec = 0;
  int   nFail = 0;
  int   mX, mY, mVel, mState;
  bit   mPend;
`ifdef PATRICK_DOUBLE_JUMP_EN
  bit   mUsed;
`endif

  patrick_motion u_dut (
    .CLK(CLK), .Reset(Reset), .frame_clk(frame_clk), .Ball_X_Move(Ball_X_Move),
    .jump_req(jump_req), .Ball_X_Pos(Ball_X_Pos), .Ball_Y_Pos(Ball_Y_Pos),
    .airborne(airborne), .Ball_Y_Vel(Ball_Y_Vel)
  );

  patrick_motion #(.GROUND_Y(50)) u_ceil (
    .CLK(CLK), .Reset(Reset), .frame_clk(frame_clk), .Ball_X_Move(Ball_X_Move),
    .jump_req(jump_req), .Ball_X_Pos(cX), .Ball_Y_Pos(cY),
    .airborne(cAir), .Ball_Y_Vel(cVel)
  );

  always #5 CLK = ~CLK;

  function automatic void modelReset();
    mX = 320; mY = 400; mVel = 0; mState = 0; mPend = 0;
`ifdef PATRICK_DOUBLE_JUMP_EN
    mUsed = 0;
`endif
    sbQ.delete();
  endfunction

  // Behavioural frame update; states 0=ground 1=rise 2=fall.
  function automatic void modelStep(input int move);
    obs_t e;
    mX = mX + move;
    if (mX < 0) mX = 0;
    else if (mX > 620) mX = 620;
    if (mState == 0) begin
      mY = 400;
      if (mPend) begin mState = 1; mVel = 12; end
      else mVel = 0;
    end
`ifdef PATRICK_DOUBLE_JUMP_EN
    else if (mPend && !mUsed) begin
      mVel = 12; mState = 1; mUsed = 1;
    end
`endif
    else if (mState == 1) begin
      if (mY - mVel < 0) begin mY = 0; mVel = 0; mState = 2; end
      else begin
        mY = mY - mVel;
        mVel = mVel - 1;
        if (mVel <= 0) begin mVel = 0; mState = 2; end
      end
    end else begin
      mVel = (mVel + 1 > 12) ? 12 : mVel + 1;
      if (mY + mVel >= 400) begin
        mY = 400; mVel = 0; mState = 0;
`ifdef PATRICK_DOUBLE_JUMP_EN
        mUsed = 0;
`endif
      end else mY = mY + mVel;
    end
    mPend = 0;
    e.x = 10'(mX); e.y = 10'(mY); e.vel = 10'(mVel); e.air = (mState != 0);
    sbQ.push_back(e);
  endfunction

  // One frame: raise frame_clk (optionally with a coincident jump), keep it
  // high for extra cycles if asked, then drop it so the next rise is seen.
  task automatic applyStimulus(input bit jmp, input int hold);
    @(negedge CLK);
    frame_clk = 1'b1;
    jump_req  = jmp;
    if (jmp) mPend = 1;
    modelStep($signed(Ball_X_Move));
    @(negedge CLK);
    jump_req = 1'b0;
    repeat (hold) @(negedge CLK);
    frame_clk = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulseJump();
    @(negedge CLK);
    jump_req = 1'b1;
    mPend = 1;
    @(negedge CLK);
    jump_req = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; jump_req = 1'b0; Ball_X_Move = 10'd0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    modelReset();
    got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne};
    nVec++;
    if (got !== {10'd320, 10'd400, 10'd0, 1'b0}) begin
      nFail++; $display("[TB] FAIL reset_state got x=%0d y=%0d v=%0d a=%0b want 320/400/0/0",
                        got.x, got.y, got.vel, got.air);
    end
    pulseJump();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp) begin
        nFail++; $display("[TB] FAIL preflight[%0d] got %h want %h", k, got, exp);
      end
    end
    nVec++;
    if (Ball_Y_Pos !== 10'd358 || airborne !== 1'b1) begin
      nFail++; $display("[TB] FAIL midflight y=%0d a=%0b want 358/1", Ball_Y_Pos, airborne);
    end
    // Async reset mid-cycle, checked before any clock edge.
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne};
    nVec++;
    if (got !== {10'd320, 10'd400, 10'd0, 1'b0}) begin
      nFail++; $display("[TB] FAIL async_reset got x=%0d y=%0d v=%0d a=%0b want 320/400/0/0",
                        got.x, got.y, got.vel, got.air);
    end
    @(negedge CLK);
    Reset = 1'b0;
    modelReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp || got !== {10'd320, 10'd400, 10'd0, 1'b0}) begin
        nFail++; $display("[TB] FAIL idle[%0d] got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_x_clamp();
    int moves[9] = '{294, 3, 3, 3, 511, -511, -107, -3, -3};
    int expX[9]  = '{614, 617, 620, 620, 620, 109, 2, 0, 0};
    for (int i = 0; i < 9; i++) begin
      Ball_X_Move = 10'(moves[i]);
      applyStimulus(1'b0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp || Ball_X_Pos !== 10'(expX[i])) begin
        nFail++; $display("[TB] FAIL x_step[%0d] got x=%0d want x=%0d (model %h got %h)",
                          i, Ball_X_Pos, expX[i], exp, got);
      end
    end
    Ball_X_Move = 10'd0;
  endtask

  task automatic test_full_jump();
    int airCnt = 0;
    pulseJump();
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1'b0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp) begin
        nFail++; $display("[TB] FAIL jump[%0d] got %h want %h", k, got, exp);
      end
      if (airborne) airCnt++;
      if (k == 0 || k == 12 || k == 23 || k == 24) begin
        nVec++;
        if ((k == 0  && {Ball_Y_Pos, Ball_Y_Vel, airborne} !== {10'd400, 10'd12, 1'b1}) ||
            (k == 12 && {Ball_Y_Pos, Ball_Y_Vel, airborne} !== {10'd322, 10'd0, 1'b1})  ||
            (k == 23 && {Ball_Y_Pos, airborne} !== {10'd388, 1'b1}) ||
            (k == 24 && {Ball_Y_Pos, Ball_Y_Vel, airborne} !== {10'd400, 10'd0, 1'b0})) begin
          nFail++; $display("[TB] FAIL jump_mark[%0d] got y=%0d v=%0d a=%0b", k,
                            Ball_Y_Pos, Ball_Y_Vel, airborne);
        end
      end
    end
    nVec++;
    if (airCnt != 24) begin
      nFail++; $display("[TB] FAIL air_ticks got %0d want 24", airCnt);
    end
  endtask

  task automatic test_airborne_req();
    bit landed = 0;
    pulseJump();
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1'b0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp) begin
        nFail++; $display("[TB] FAIL rise2[%0d] got %h want %h", k, got, exp);
      end
    end
    pulseJump();
    applyStimulus(1'b0, 0);
    got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
`ifdef PATRICK_DOUBLE_JUMP_EN
    if (got !== exp || {Ball_Y_Pos, Ball_Y_Vel} !== {10'd322, 10'd12}) begin
`else
    if (got !== exp || {Ball_Y_Pos, Ball_Y_Vel} !== {10'd323, 10'd1}) begin
`endif
      nFail++; $display("[TB] FAIL apex_req got y=%0d v=%0d (model %h)", Ball_Y_Pos, Ball_Y_Vel, exp);
    end
    for (int k = 0; k < 80 && !landed; k++) begin
      if (k == 3) pulseJump();
      applyStimulus(1'b0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp) begin
        nFail++; $display("[TB] FAIL after_apex[%0d] got %h want %h", k, got, exp);
      end
      if (!airborne) landed = 1;
    end
    nVec++;
    if (!landed) begin
      nFail++; $display("[TB] FAIL land_timeout airborne=%0b want 0", airborne);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp || airborne !== 1'b0) begin
        nFail++; $display("[TB] FAIL stale_pending[%0d] got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_coincide();
    for (int pass = 0; pass < 2; pass++) begin
      bit landed = 0;
      // pass 0: jump on the tick cycle; pass 1: same but frame_clk held 10 cycles
      applyStimulus(1'b1, pass * 10);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp || {Ball_Y_Pos, Ball_Y_Vel, airborne} !== {10'd400, 10'd12, 1'b1}) begin
        nFail++; $display("[TB] FAIL coincide[%0d] got y=%0d v=%0d a=%0b want 400/12/1",
                          pass, Ball_Y_Pos, Ball_Y_Vel, airborne);
      end
      for (int k = 0; k < 80 && !landed; k++) begin
        applyStimulus(1'b0, 0);
        got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
        if (got !== exp) begin
          nFail++; $display("[TB] FAIL coin_fly[%0d] got %h want %h", k, got, exp);
        end
        if (!airborne) landed = 1;
      end
      nVec++;
      if (!landed) begin
        nFail++; $display("[TB] FAIL coin_land_timeout airborne=%0b want 0", airborne);
      end
    end
    Ball_X_Move = 10'd5;
    applyStimulus(1'b0, 10);
    got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
    if (got !== exp || Ball_X_Pos !== 10'd5) begin
      nFail++; $display("[TB] FAIL held_frame got x=%0d want 5", Ball_X_Pos);
    end
    Ball_X_Move = 10'd0;
  endtask

  task automatic test_ceiling();
    int cy[8] = '{50, 38, 27, 17, 8, 0, 0, 1};
    int cv[8] = '{12, 11, 10, 9, 8, 7, 0, 1};
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    modelReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k == 0, 0);
      got = {Ball_X_Pos, Ball_Y_Pos, Ball_Y_Vel, airborne}; exp = sbQ.pop_front(); nVec++;
      if (got !== exp) begin
        nFail++; $display("[TB] FAIL ceil_main[%0d] got %h want %h", k, got, exp);
      end
      nVec++;
      if (cY !== 10'(cy[k]) || cVel !== 10'(cv[k]) || cAir !== 1'b1) begin
        nFail++; $display("[TB] FAIL ceiling[%0d] got y=%0d v=%0d a=%0b want %0d/%0d/1",
                          k, cY, cVel, cAir, cy[k], cv[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_x_clamp();
    test_full_jump();
    test_airborne_req();
    test_coincide();
    test_ceiling();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
